// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB burst arbiter: transfer/burst encodings, FSM states, beat lookup.
// The LOCK state exists only when AHB_ARB_LOCK_EN is defined.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_t;

`ifdef AHB_ARB_LOCK_EN
  typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_BURST, ST_LOCK} arb_state_t;
`else
  typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_BURST} arb_state_t;
`endif

  localparam int CNT_W = 4;

  // Remaining beats after the first one; undefined-length bursts count as single.
  function automatic logic [CNT_W-1:0] burst_beats(input hburst_t b);
    case (b)
      HB_WRAP4,  HB_INCR4:  burst_beats = 4'd3;
      HB_WRAP8,  HB_INCR8:  burst_beats = 4'd7;
      HB_WRAP16, HB_INCR16: burst_beats = 4'd15;
      default:              burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_arbiter_rr.sv
// Round-robin picker: first requester found after the pointer position, wrapping around.
// Produces a one-hot winner plus a valid flag when any request is present.
module ahb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          vld_o
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    // Search starts one past the pointer so the last owner is considered last.
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr_i) + i) % N);
      if (!vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_burst_arbiter.sv
// AHB bus arbiter with fixed-length burst protection and round-robin fairness.
// Define AHB_ARB_LOCK_EN to honour m_hlock (LOCK state, s_hmastlock); otherwise locking is ignored.
module ahb_burst_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [NUM_MASTERS-1:0]         m_busreq,
  input  logic [NUM_MASTERS-1:0]         m_hlock,
  input  logic [1:0]                     s_htrans,
  input  logic [2:0]                     s_hburst,
  input  logic                           s_hready,
  output logic [NUM_MASTERS-1:0]         hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] s_hmaster,
  output logic                           s_hmastlock
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_OH  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [IW-1:0]          DEF_IDX = IW'(DEFAULT_MASTER);

  arb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [IW-1:0]          hmaster_q, hmaster_d;
  logic                   mastlock_q, mastlock_d;

  logic [IW-1:0]          gidx;
  logic [NUM_MASTERS-1:0] win_oh;
  logic                   win_vld;
  logic                   arb_ok;
  logic                   lock_hold;
  htrans_t                ht;
  hburst_t                hb;

  assign ht = htrans_t'(s_htrans);
  assign hb = hburst_t'(s_hburst);

  // The address-phase owner doubles as the round-robin pointer.
  ahb_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req_i (m_busreq),
    .ptr_i (hmaster_q),
    .gnt_o (win_oh),
    .vld_o (win_vld)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (hgrant_q[i]) gidx = IW'(i);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s_hready) begin
      case (ht)
        HT_NONSEQ: cnt_d = burst_beats(hb);
        HT_SEQ:    cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        HT_IDLE:   cnt_d = '0;
        default:   cnt_d = cnt_q;
      endcase
    end
  end

`ifdef AHB_ARB_LOCK_EN
  assign lock_hold = (state_q == ST_LOCK) || m_hlock[gidx];
`else
  logic lock_unused;
  assign lock_unused = ^m_hlock;
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    // Re-arbitrate only once the previous count is drained and no new burst is starting.
    arb_ok     = (cnt_q == '0) && (cnt_d == '0) && !lock_hold;
    hgrant_d   = hgrant_q;
    hmaster_d  = hmaster_q;
    mastlock_d = mastlock_q;
    state_d    = state_q;
    if (arb_ok)
      hgrant_d = win_vld ? win_oh : DEF_OH;
    if (s_hready) begin
      hmaster_d = gidx;
`ifdef AHB_ARB_LOCK_EN
      mastlock_d = m_hlock[gidx];
`else
      mastlock_d = 1'b0;
`endif
      if (cnt_d != '0)
        state_d = ST_BURST;
      else if (arb_ok)
        state_d = win_vld ? ST_OWN : ST_PARK;
      else
        state_d = ST_OWN;
`ifdef AHB_ARB_LOCK_EN
      if (m_hlock[gidx] || ((state_q == ST_LOCK) && (cnt_q != '0)))
        state_d = ST_LOCK;
`endif
    end
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q    <= ST_PARK;
      cnt_q      <= '0;
      hgrant_q   <= DEF_OH;
      hmaster_q  <= DEF_IDX;
      mastlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hgrant_q   <= hgrant_d;
      hmaster_q  <= hmaster_d;
      mastlock_q <= mastlock_d;
    end
  end

  assign hgrant      = hgrant_q;
  assign s_hmaster   = hmaster_q;
  assign s_hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Directed bench for ahb_burst_arbiter (4 masters, default master 0): stimulus pushes expected
// grant/owner/lock tuples into a queue; a monitor pops one per clock edge or reset assertion.
module tb_ahb_burst_arbiter;

  localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;

  logic       hclk = 1'b0;
  logic       hreset = 1'b0;
  logic [3:0] m_busreq = '0;
  logic [3:0] m_hlock = '0;
  logic [1:0] s_htrans = IDLE;
  logic [2:0] s_hburst = SINGLE;
  logic       s_hready = 1'b1;
  logic [3:0] hgrant;
  logic [1:0] s_hmaster;
  logic       s_hmastlock;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] mst;
    logic       lk;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  logic [3:0] rr_g [10];
  logic [1:0] rr_m [10];

  ahb_burst_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .m_busreq    (m_busreq),
    .m_hlock     (m_hlock),
    .s_htrans    (s_htrans),
    .s_hburst    (s_hburst),
    .s_hready    (s_hready),
    .hgrant      (hgrant),
    .s_hmaster   (s_hmaster),
    .s_hmastlock (s_hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic push_exp(input string tag, input logic [3:0] g, input logic [1:0] m, input logic l);
    exp_t e;
    e.tag = tag;
    e.gnt = g;
    e.mst = m;
    e.lk  = l;
    exp_q.push_back(e);
  endtask

  task automatic step(input string tag, input logic rst, input logic [3:0] req, input logic [3:0] lck,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] em, input logic el);
    @(negedge hclk);
    hreset   = rst;
    m_busreq = req;
    m_hlock  = lck;
    s_htrans = tr;
    s_hburst = bu;
    s_hready = rdy;
    push_exp(tag, eg, em, el);
  endtask

  task automatic async_reset(input string tag);
    @(posedge hclk);
    #3;
    push_exp(tag, 4'b0001, 2'd0, 1'b0);
    hreset = 1'b0;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge hclk or negedge hreset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (hgrant === e.gnt && s_hmaster === e.mst && s_hmastlock === e.lk)
          n_pass++;
        else
          $display("FAIL %s: got hgrant=%b s_hmaster=%0d s_hmastlock=%b, want hgrant=%b s_hmaster=%0d s_hmastlock=%b",
                   e.tag, hgrant, s_hmaster, s_hmastlock, e.gnt, e.mst, e.lk);
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rr_g = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    rr_m = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};

    // Reset and parking with no requests
    repeat (2) step("rst_hold", 1'b0, 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
    repeat (2) step("park",     1'b1, 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);

    // All masters requesting, single transfers: owner rotates 1,2,3,0,1
    for (int i = 0; i < 10; i++)
      step("rr_single", 1'b1, 4'b1111, 4'b0000, NSQ, SINGLE, 1'b1, rr_g[i], rr_m[i], 1'b0);

    // Master 2 INCR8 holds the grant across 8 beats even after dropping its request
    step("i8_grant", 1'b1, 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
    step("i8_own",   1'b1, 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0);
    step("i8_nseq",  1'b1, 4'b0110, 4'b0000, NSQ,  INCR8,  1'b1, 4'b0100, 2'd2, 1'b0);
    repeat (7) step("i8_seq", 1'b1, 4'b0010, 4'b0000, SEQ, INCR8, 1'b1, 4'b0100, 2'd2, 1'b0);
    step("i8_rearb", 1'b1, 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd2, 1'b0);
    step("i8_hand",  1'b1, 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);

    // Master 1 INCR4 with a 3-cycle wait state in the middle
    step("i4_nseq", 1'b1, 4'b0010, 4'b0000, NSQ, INCR4, 1'b1, 4'b0010, 2'd1, 1'b0);
    step("i4_seq1", 1'b1, 4'b0011, 4'b0000, SEQ, INCR4, 1'b1, 4'b0010, 2'd1, 1'b0);
    repeat (3) step("i4_wait", 1'b1, 4'b0011, 4'b0000, SEQ, INCR4, 1'b0, 4'b0010, 2'd1, 1'b0);
    repeat (2) step("i4_seq",  1'b1, 4'b0011, 4'b0000, SEQ, INCR4, 1'b1, 4'b0010, 2'd1, 1'b0);
    step("i4_rearb", 1'b1, 4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd1, 1'b0);
    step("i4_hand",  1'b1, 4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);

    // Master 0 INCR8 cut short by IDLE: counter clears, arbitration resumes next cycle
    step("early_nseq",  1'b1, 4'b0011, 4'b0000, NSQ,  INCR8,  1'b1, 4'b0001, 2'd0, 1'b0);
    step("early_seq",   1'b1, 4'b0011, 4'b0000, SEQ,  INCR8,  1'b1, 4'b0001, 2'd0, 1'b0);
    step("early_idle",  1'b1, 4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
    step("early_rearb", 1'b1, 4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
    step("early_own",   1'b1, 4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);

    // Master 3 with m_hlock over two INCR4 bursts while everyone requests
    step("lk_grant", 1'b1, 4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd1, 1'b0);
`ifdef AHB_ARB_LOCK_EN
    step("lk_own",   1'b1, 4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd3, 1'b1);
    step("lk_nseq1", 1'b1, 4'b1111, 4'b1000, NSQ,  INCR4,  1'b1, 4'b1000, 2'd3, 1'b1);
    repeat (3) step("lk_seq1", 1'b1, 4'b1111, 4'b1000, SEQ, INCR4, 1'b1, 4'b1000, 2'd3, 1'b1);
    step("lk_gap",   1'b1, 4'b1111, 4'b1000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd3, 1'b1);
    step("lk_nseq2", 1'b1, 4'b1111, 4'b1000, NSQ,  INCR4,  1'b1, 4'b1000, 2'd3, 1'b1);
    repeat (3) step("lk_seq2", 1'b1, 4'b1111, 4'b1000, SEQ, INCR4, 1'b1, 4'b1000, 2'd3, 1'b1);
    step("lk_last",  1'b1, 4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd3, 1'b0);
    step("lk_rearb", 1'b1, 4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);
    step("lk_hand",  1'b1, 4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
`else
    step("nolk_own",  1'b1, 4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, 4'b1000, 2'd3, 1'b0);
    step("nolk_nseq", 1'b1, 4'b1111, 4'b1000, NSQ,  INCR4,  1'b1, 4'b1000, 2'd3, 1'b0);
    repeat (3) step("nolk_seq", 1'b1, 4'b1111, 4'b1000, SEQ, INCR4, 1'b1, 4'b1000, 2'd3, 1'b0);
    step("nolk_rearb", 1'b1, 4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);
    step("nolk_hand",  1'b1, 4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
`endif

    // Master 1 INCR16 aborted by reset at beat 5
    step("i16_grant", 1'b1, 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
    step("i16_own",   1'b1, 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);
    step("i16_nseq",  1'b1, 4'b0010, 4'b0000, NSQ,  INCR16, 1'b1, 4'b0010, 2'd1, 1'b0);
    repeat (4) step("i16_seq", 1'b1, 4'b0010, 4'b0000, SEQ, INCR16, 1'b1, 4'b0010, 2'd1, 1'b0);
    async_reset("i16_areset");
    repeat (2) step("i16_rst", 1'b0, 4'b0010, 4'b0000, SEQ, INCR16, 1'b1, 4'b0001, 2'd0, 1'b0);
    step("post_rst_arb", 1'b1, 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd0, 1'b0);
    step("post_rst_own", 1'b1, 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge hclk);
    #2;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
      n_chk = n_chk + exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_burst_arbiter.md
AHB_BURST_ARBITER -- requirements
Module: ahb_burst_arbiter

Interface
- REQ-001: Parameter NUM_MASTERS, 4, number of requesting masters (2..16).
- REQ-002: Parameter DEFAULT_MASTER, 0, master parked on the bus when no request is pending.
- REQ-003: hclk  input  1  sole clock; all state updates on rising edge.
- REQ-004: hreset  input  1  asynchronous, active-low reset.
- REQ-005: m_busreq  input  NUM_MASTERS  per-master bus request.
- REQ-006: m_hlock  input  NUM_MASTERS  per-master locked-transfer request.
- REQ-007: s_htrans  input  2  muxed HTRANS of current address-phase owner.
- REQ-008: s_hburst  input  3  muxed HBURST of current address-phase owner.
- REQ-009: s_hready  input  1  bus HREADY.
- REQ-010: hgrant  output  NUM_MASTERS  registered one-hot grant.
- REQ-011: s_hmaster  output  $clog2(NUM_MASTERS)  index of address-phase owner.
- REQ-012: s_hmastlock  output  1  current address phase is locked.

Function
- REQ-013: HTRANS encodings SHALL be IDLE=00, BUSY=01, NONSEQ=10, SEQ=11; HBURST encodings SHALL be SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
- REQ-014: FSM states SHALL be PARK (default master, no requests), OWN (owner may be re-arbitrated), BURST (fixed-length burst in progress), LOCK (locked sequence in progress).
- REQ-015: Beat counter SHALL load beats-1 (SINGLE/INCR 0, x4 3, x8 7, x16 15) on NONSEQ with s_hready=1, decrement on SEQ with s_hready=1, hold on BUSY or s_hready=0, never wrap below 0.
- REQ-016: Arbitration SHALL be allowed only when counter==0 and not in LOCK; PARK/OWN -> BURST on fixed-length NONSEQ; BURST -> OWN when counter reaches 0.
- REQ-017: Winner SHALL be round-robin among m_busreq starting at (last owner+1) mod NUM_MASTERS; no request -> DEFAULT_MASTER and PARK.
- REQ-018: hgrant SHALL update one cycle after the arbitration decision (request at edge n, hgrant at edge n+1), independent of s_hready.
- REQ-019: s_hmaster SHALL take the granted index only on an edge with s_hready=1; the round-robin pointer SHALL advance at that same edge.
- REQ-020: Early termination (IDLE or NONSEQ while counter>0, s_hready=1) SHALL clear or reload the counter accordingly.
- REQ-021: Granted master deasserting m_busreq mid-burst SHALL NOT move the grant before counter==0.
- REQ-022: s_hready=0 SHALL freeze FSM, counter, s_hmaster and s_hmastlock.

Reset
- REQ-023: While hreset=0: hgrant one-hot DEFAULT_MASTER, s_hmaster=DEFAULT_MASTER, s_hmastlock=0, counter=0, pointer=DEFAULT_MASTER, state PARK; reset mid-burst SHALL abort immediately.

Configuration
- REQ-024: Macro AHB_ARB_LOCK_EN defined: owner with m_hlock=1 enters LOCK, grant held until its m_hlock=0 and counter==0, then one further transfer; s_hmastlock = owner's m_hlock sampled with s_hmaster.
- REQ-025: Macro undefined: m_hlock ignored, LOCK state absent, s_hmastlock tied 0.

Structure
- REQ-026: Package ahb_arb_pkg SHALL hold htrans_t and hburst_t enums, arbiter state enum and a burst-to-beats function.
- REQ-027: Round-robin selection SHALL be a sub-module ahb_rr_picker (request vector + pointer -> one-hot winner, valid).

Verification (NUM_MASTERS=4, DEFAULT_MASTER=0)
- REQ-028: Reset released, m_busreq=0000 -> hgrant=0001, s_hmaster=0, s_hmastlock=0, state PARK.
- REQ-029: m_busreq=1111 constant, SINGLE transfers, s_hready=1 -> s_hmaster sequence 1,2,3,0,1.
- REQ-030: Master 2 INCR8, master 1 requesting -> hgrant stays 0100 for 8 accepted beats; 0010 one cycle after counter reaches 0.
- REQ-031: s_hready=0 for 3 cycles mid-INCR4 -> counter and s_hmaster unchanged; burst completes after 4 accepted beats.
- REQ-032: AHB_ARB_LOCK_EN, master 3 m_hlock=1 over two INCR4 bursts, m_busreq=1111 -> hgrant=1000 throughout, s_hmastlock=1 for all 8 beats.
- REQ-033: hreset=0 asserted at beat 5 of INCR16 on master 1 -> hgrant=0001, s_hmaster=0 same cycle, counter=0.
